// File: rtl/fifo_stream_reader.sv
// Pops words from a registered-output FIFO read port and presents them on a
// valid/ready stream through a small skid buffer, counting delivered words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  words_read
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  xfer;
    logic [OCC_W:0]        occ_sum;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        out_valid  = ~rst & (occ_q != '0);
        xfer       = out_valid & out_ready;
        occ_sum    = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(xfer);
        fifo_rd_en = ~rst & ~fifo_empty & (occ_sum < DEPTH_EXT);
        occ_d      = occ_sum[OCC_W-1:0];
        out_data   = mem_q[head_q];

        head_d = head_q;
        if (xfer) begin
            head_d = (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
        end

        // The word popped last cycle lands now; store it at the tail.
        tail_d = tail_q;
        if (inflight_q) begin
            tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: the data storage carries no reset; occ gates its visibility, and
    // leaving it unreset lets it map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (inflight_q && !rst) begin
            mem_q[tail_q] <= fifo_dout;
        end
    end

    assign words_read = cnt_q;

    occ_bound_a: assert property (@(posedge clk) disable iff (rst)
        {1'b0, occ_q} <= DEPTH_EXT);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random checks of fifo_stream_reader against a behavioural FIFO
// with registered read data and an in-order scoreboard.
module tb_fifo_stream_reader;

    localparam int BUF_DEPTH = 2;
    localparam int FMEM      = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        cnt_clear;
    logic [31:0] words_read;

    fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(BUF_DEPTH), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cnt_clear  (cnt_clear),
        .words_read (words_read)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural FIFO: dout registered one cycle after an accepted pop.
    logic [7:0] fmem [FMEM];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= fmem[rd_ptr % FMEM];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [7:0]  exp_q [$];
    logic [31:0] model_cnt = '0;
    int          pending   = 0;
    int          rd_cnt    = 0;
    logic        mon_en    = 1'b0;
    logic        stall_q   = 1'b0;
    logic [7:0]  held      = '0;
    logic        xfer_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr % FMEM] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Monitor: scoreboard, counter model, stall stability and pop-rule checks.
    always @(negedge clk) begin
        if (mon_en) begin
            xfer_m = out_valid & out_ready;
            check("words_read", words_read, model_cnt);
            if (rst) begin
                check("rst_rd_en", 32'(fifo_rd_en), 0);
                check("rst_valid", 32'(out_valid), 0);
                pending   = 0;
                model_cnt = '0;
                stall_q   = 1'b0;
                exp_q.delete();
                for (int p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(fmem[p % FMEM]);
            end else begin
                if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 0);
                if (stall_q) begin
                    check("valid_hold", 32'(out_valid), 1);
                    check("data_hold", 32'(out_data), 32'(held));
                end
                if (xfer_m) begin
                    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                pending = pending + int'(fifo_rd_en) - int'(xfer_m);
                rd_cnt  = rd_cnt + int'(fifo_rd_en);
                check("occ_bound", 32'(pending <= BUF_DEPTH), 1);
                if (cnt_clear) model_cnt = '0;
                else if (xfer_m) model_cnt = model_cnt + 1;
                stall_q = out_valid & ~out_ready;
                held    = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int rd_base;
        int pushed;

        rst       = 1'b1;
        out_ready = 1'b0;
        cnt_clear = 1'b0;

        // Reset then idle
        @(posedge clk);
        #1 mon_en = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) begin
            wait_neg();
            check("idle_valid", 32'(out_valid), 0);
            check("idle_rd_en", 32'(fifo_rd_en), 0);
        end

        // Single word: pop in N, valid in N+2 for exactly one cycle
        step();
        out_ready = 1'b1;
        push(8'hA5);
        wait_neg();
        check("lat_rd_en_N", 32'(fifo_rd_en), 1);
        wait_neg();
        check("lat_valid_N1", 32'(out_valid), 0);
        wait_neg();
        check("lat_valid_N2", 32'(out_valid), 1);
        check("lat_data_N2", 32'(out_data), 32'h A5);
        wait_neg();
        check("lat_valid_N3", 32'(out_valid), 0);
        check("lat_count", words_read, 1);

        // Streaming 32 words without bubbles
        step();
        for (int i = 0; i < 32; i++) push(8'(i));
        cyc = 0;
        wait_neg();
        while (!out_valid && cyc < 10) begin
            wait_neg();
            cyc++;
        end
        for (int i = 0; i < 32; i++) begin
            check("stream_no_bubble", 32'(out_valid), 1);
            wait_neg();
        end
        check("stream_end_valid", 32'(out_valid), 0);
        check("stream_count", words_read, 33);

        // Backpressure: only BUF_DEPTH pops while stalled, head word held
        step();
        out_ready = 1'b0;
        rd_base   = rd_cnt;
        for (int i = 0; i < 8; i++) push(8'(i));
        repeat (10) wait_neg();
        check("bp_pops", 32'(rd_cnt - rd_base), BUF_DEPTH);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_head", 32'(out_data), 32'h00);
        step();
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            wait_neg();
            cyc++;
        end
        check("bp_drain", 32'(exp_q.size()), 0);
        wait_neg();
        check("bp_count", words_read, 41);

        // Random ready and random fill, 1000 words
        pushed = 0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            step();
            out_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            if (pushed == 1000 && exp_q.size() == 0) break;
        end
        check("rand_pushed", 32'(pushed), 1000);
        check("rand_drain", 32'(exp_q.size()), 0);
        out_ready = 1'b1;
        wait_neg();
        check("rand_count", words_read, 1041);

        // Reset mid-stream with a pop in flight
        step();
        out_ready = 1'b0;
        push(8'hE0);
        push(8'hE1);
        push(8'hE2);
        repeat (5) step();
        wait_neg();
        check("mid_head", 32'(out_data), 32'h E0);
        check("mid_valid", 32'(out_valid), 1);
        step();
        out_ready = 1'b1;
        wait_neg();
        check("mid_pop", 32'(fifo_rd_en), 1);
        step();
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) begin
            wait_neg();
            check("post_rst_valid", 32'(out_valid), 0);
            check("post_rst_rd_en", 32'(fifo_rd_en), 0);
        end
        check("post_rst_count", words_read, 0);

        // Word to rebuild a nonzero count, then clear together with a transfer
        step();
        out_ready = 1'b1;
        push(8'h11);
        repeat (4) step();
        wait_neg();
        check("pre_clear_count", words_read, 1);
        step();
        push(8'h5A);
        step();
        step();
        cnt_clear = 1'b1;
        wait_neg();
        check("clr_xfer_valid", 32'(out_valid), 1);
        step();
        cnt_clear = 1'b0;
        wait_neg();
        check("clr_priority", words_read, 0);
        check("clr_drain", 32'(exp_q.size()), 0);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
